// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Single-port memory-mapped responder. It holds a RAM of 16-bit words in the
// lower half of a 9-bit word address space, plus an 8-bit LED output register
// and an 8-bit switch input port in the upper half. A small FSM
// (IDLE / ACK / HOLD) turns a command that is held on the bus for several
// cycles into exactly one acknowledged access. It also makes sure that a held
// WRITE is committed only once.
//
// Ports
//   clk         in   1   rising-edge clock
//   reset       in   1   asynchronous, active-low reset
//   mem_cmd     in   2   00 NONE, 01 READ, 10 WRITE, 11 illegal
//   mem_addr    in   9   word address
//   write_data  in  16   store data
//   sw          in   8   switch inputs
//   read_data   out 16   registered read data (one-cycle latency)
//   rdy         out  1   one-cycle acknowledge of a new access
//   ledr        out  8   LED register
//   err         out  1   sticky error flag (cleared only by reset)
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int unsigned RAM_WORDS = 256,
  parameter logic [8:0]  LED_ADDR  = 9'h100,
  parameter logic [8:0]  SW_ADDR   = 9'h140
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  input  logic [7:0]  sw,
  output logic [15:0] read_data,
  output logic        rdy,
  output logic [7:0]  ledr,
  output logic        err
);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_ILL   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACK  = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [15:0] ram_q [RAM_WORDS];

  state_e      state_q, state_d;
  logic [10:0] acc_q, acc_d;          // latched {mem_cmd, mem_addr} of the current access
  logic [15:0] read_data_q, read_data_d;
  logic        rdy_q, rdy_d;
  logic [7:0]  ledr_q, ledr_d;
  logic        err_q, err_d;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [10:0] cur_acc_s;
  logic        is_ram_s;
  logic        is_sw_s;
  logic        is_led_s;
  logic        acc_err_s;
  logic        enter_ack_s;
  logic        ram_we_s;
  logic        led_we_s;
  logic [15:0] rd_val_s;

  assign cur_acc_s = {mem_cmd, mem_addr};

  // Address decode: lower half is RAM (if the index exists), upper half holds the ports.
  always_comb begin
    is_ram_s = 1'b0;
    is_sw_s  = 1'b0;
    is_led_s = 1'b0;
    if (mem_addr[8] == 1'b0) begin
      is_ram_s = ({24'h000000, mem_addr[7:0]} < RAM_WORDS);
    end else begin
      is_sw_s  = (mem_addr == SW_ADDR);
      is_led_s = (mem_addr == LED_ADDR);
    end
  end

  // Error classification of the access currently on the bus.
  always_comb begin
    acc_err_s = 1'b0;
    case (mem_cmd)
      CMD_NONE:  acc_err_s = 1'b0;
      CMD_READ:  acc_err_s = !(is_ram_s || is_sw_s || is_led_s);
      CMD_WRITE: acc_err_s = !(is_ram_s || is_led_s);
      CMD_ILL:   acc_err_s = 1'b1;
      default:   acc_err_s = 1'b1;
    endcase
  end

  // Read mux: LED port is write-only and unmapped space reads as zero.
  always_comb begin
    rd_val_s = 16'h0000;
    if (is_ram_s) begin
      rd_val_s = ram_q[mem_addr[7:0]];
    end else if (is_sw_s) begin
      rd_val_s = {8'h00, sw};
    end else begin
      rd_val_s = 16'h0000;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  // Next-state logic: a bus value equal to the latched access is the same
  // access still being held; any other non-NONE value is a new access.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (mem_cmd != CMD_NONE) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK, ST_HOLD: begin
        if (cur_acc_s == acc_q) begin
          state_d = ST_HOLD;
        end else if (mem_cmd == CMD_NONE) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_ack_s = (state_d == ST_ACK);

  // Side effects happen only on the edge that enters ACK. A held WRITE
  // therefore commits once. The RAM enable is also gated by reset: an edge
  // seen while reset is asserted must not write.
  assign ram_we_s = reset && enter_ack_s && (mem_cmd == CMD_WRITE) && is_ram_s;
  assign led_we_s = enter_ack_s && (mem_cmd == CMD_WRITE) && is_led_s;

  // Next values for the latched access and the registered outputs.
  always_comb begin
    acc_d       = acc_q;
    read_data_d = read_data_q;
    ledr_d      = ledr_q;
    err_d       = err_q;
    rdy_d       = enter_ack_s;

    if (enter_ack_s) begin
      acc_d = cur_acc_s;
    end else begin
      acc_d = acc_q;
    end

    // A READ reloads the data on every edge, so a held READ tracks the source.
    if (mem_cmd == CMD_READ) begin
      read_data_d = rd_val_s;
    end else begin
      read_data_d = read_data_q;
    end

    if (led_we_s) begin
      ledr_d = write_data[7:0];
    end else begin
      ledr_d = ledr_q;
    end

    // The error flag is sticky: it is only ever set here, and only reset clears it.
    if (enter_ack_s && acc_err_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------
  // State, latched access and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= 11'h000;
      read_data_q <= 16'h0000;
      rdy_q       <= 1'b0;
      ledr_q      <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      read_data_q <= read_data_d;
      rdy_q       <= rdy_d;
      ledr_q      <= ledr_d;
      err_q       <= err_d;
    end
  end

  // RAM array: contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_q[mem_addr[7:0]] <= write_data;
    end
  end

  assign read_data = read_data_q;
  assign rdy       = rdy_q;
  assign ledr      = ledr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Self-checking bench for mem_responder. It has three parts:
//   - a table of directed vectors, applied and compared in a loop;
//   - hand-written reset sequences;
//   - randomized traffic checked against a behavioural model.
//
// The model is written in terms of the bus history only. A new access is any
// non-NONE {cmd, addr} that differs from the value on the previous edge,
// counting from reset.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [7:0]  sw;
  logic [15:0] read_data;
  logic        rdy;
  logic [7:0]  ledr;
  logic        err;

  always #5 clk = ~clk;

  mem_responder #(
    .RAM_WORDS (256),
    .LED_ADDR  (9'h100),
    .SW_ADDR   (9'h140)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .sw         (sw),
    .read_data  (read_data),
    .rdy        (rdy),
    .ledr       (ledr),
    .err        (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------------------------------------------------------------------
  // Behavioural reference model
  // ---------------------------------------------------------------------------
  logic [15:0] m_ram [256];
  logic [10:0] m_prev;
  logic        m_rdy;
  logic [15:0] m_rd;
  logic [7:0]  m_led;
  logic        m_err;

  task automatic model_reset();
    m_prev = 11'h000;
    m_rdy  = 1'b0;
    m_rd   = 16'h0000;
    m_led  = 8'h00;
    m_err  = 1'b0;
  endtask

  task automatic model_edge();
    logic [10:0] cur;
    logic        in_ram, at_sw, at_led, fresh;
    cur    = {mem_cmd, mem_addr};
    in_ram = (mem_addr[8] == 1'b0);
    at_sw  = (mem_addr == 9'h140);
    at_led = (mem_addr == 9'h100);
    fresh  = (mem_cmd != 2'b00) && (cur != m_prev);
    if (mem_cmd == 2'b01)
      m_rd = in_ram ? m_ram[mem_addr[7:0]] : (at_sw ? {8'h00, sw} : 16'h0000);
    if (fresh) begin
      if (mem_cmd == 2'b10) begin
        if (in_ram)      m_ram[mem_addr[7:0]] = write_data;
        else if (at_led) m_led = write_data[7:0];
        else             m_err = 1'b1;
      end else if (mem_cmd == 2'b11) begin
        m_err = 1'b1;
      end else if (!in_ram && !at_sw && !at_led) begin
        m_err = 1'b1;
      end
    end
    m_rdy  = fresh;
    m_prev = cur;
  endtask

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk4(input string name, input logic e_rdy, input logic [15:0] e_rd,
                      input logic [7:0] e_led, input logic e_err);
    chk({name, ".rdy"},       {15'h0000, rdy}, {15'h0000, e_rdy});
    chk({name, ".read_data"}, read_data, e_rd);
    chk({name, ".ledr"},      {8'h00, ledr}, {8'h00, e_led});
    chk({name, ".err"},       {15'h0000, err}, {15'h0000, e_err});
  endtask

  task automatic drive(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d,
                       input logic [7:0] s);
    mem_cmd    = c;
    mem_addr   = a;
    write_data = d;
    sw         = s;
  endtask

  // One clock edge; the model sees the same inputs. Ends 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    else       model_reset();
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wd;
    logic [7:0]  sw;
    logic        e_rdy;
    logic [15:0] e_rd;
    logic [7:0]  e_led;
    logic        e_err;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d,
                              input logic [7:0] s, input logic r, input logic [15:0] rd,
                              input logic [7:0] l, input logic e);
    vec_t v;
    v.cmd = c; v.addr = a; v.wd = d; v.sw = s;
    v.e_rdy = r; v.e_rd = rd; v.e_led = l; v.e_err = e;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    // Before the table runs, RAM word i holds {8'hC0, i}.
    // write then read
    tbl[0]  = mk(2'b10, 9'h005, 16'hABCD, 8'h00, 1'b1, 16'h0000, 8'h00, 1'b0);
    tbl[1]  = mk(2'b00, 9'h000, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0);
    tbl[2]  = mk(2'b01, 9'h005, 16'h0000, 8'h00, 1'b1, 16'hABCD, 8'h00, 1'b0);
    tbl[3]  = mk(2'b01, 9'h005, 16'h0000, 8'h00, 1'b0, 16'hABCD, 8'h00, 1'b0);
    tbl[4]  = mk(2'b00, 9'h000, 16'h0000, 8'h00, 1'b0, 16'hABCD, 8'h00, 1'b0);
    // held write commits only the first data
    tbl[5]  = mk(2'b10, 9'h010, 16'h1111, 8'h00, 1'b1, 16'hABCD, 8'h00, 1'b0);
    tbl[6]  = mk(2'b10, 9'h010, 16'h2222, 8'h00, 1'b0, 16'hABCD, 8'h00, 1'b0);
    tbl[7]  = mk(2'b10, 9'h010, 16'h2222, 8'h00, 1'b0, 16'hABCD, 8'h00, 1'b0);
    tbl[8]  = mk(2'b01, 9'h010, 16'h0000, 8'h00, 1'b1, 16'h1111, 8'h00, 1'b0);
    tbl[9]  = mk(2'b00, 9'h000, 16'h0000, 8'h00, 1'b0, 16'h1111, 8'h00, 1'b0);
    // LED and switch ports
    tbl[10] = mk(2'b10, 9'h100, 16'h00A5, 8'h00, 1'b1, 16'h1111, 8'hA5, 1'b0);
    tbl[11] = mk(2'b00, 9'h000, 16'h0000, 8'h3C, 1'b0, 16'h1111, 8'hA5, 1'b0);
    tbl[12] = mk(2'b01, 9'h140, 16'h0000, 8'h3C, 1'b1, 16'h003C, 8'hA5, 1'b0);
    tbl[13] = mk(2'b00, 9'h000, 16'h0000, 8'h3C, 1'b0, 16'h003C, 8'hA5, 1'b0);
    // address change while holding
    tbl[14] = mk(2'b01, 9'h001, 16'h0000, 8'h00, 1'b1, 16'hC001, 8'hA5, 1'b0);
    tbl[15] = mk(2'b01, 9'h001, 16'h0000, 8'h00, 1'b0, 16'hC001, 8'hA5, 1'b0);
    tbl[16] = mk(2'b01, 9'h002, 16'h0000, 8'h00, 1'b1, 16'hC002, 8'hA5, 1'b0);
    tbl[17] = mk(2'b01, 9'h002, 16'h0000, 8'h00, 1'b0, 16'hC002, 8'hA5, 1'b0);
    // back-to-back distinct accesses, read right after write
    tbl[18] = mk(2'b01, 9'h005, 16'h0000, 8'h00, 1'b1, 16'hABCD, 8'hA5, 1'b0);
    tbl[19] = mk(2'b10, 9'h003, 16'h1234, 8'h00, 1'b1, 16'hABCD, 8'hA5, 1'b0);
    tbl[20] = mk(2'b01, 9'h003, 16'h0000, 8'h00, 1'b1, 16'h1234, 8'hA5, 1'b0);
    tbl[21] = mk(2'b01, 9'h100, 16'h0000, 8'h00, 1'b1, 16'h0000, 8'hA5, 1'b0);
    tbl[22] = mk(2'b00, 9'h000, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'hA5, 1'b0);
    // error cases; the illegal command at 9'h005 must not write RAM
    tbl[23] = mk(2'b11, 9'h005, 16'hFFFF, 8'h00, 1'b1, 16'h0000, 8'hA5, 1'b1);
    tbl[24] = mk(2'b10, 9'h140, 16'h00FF, 8'h00, 1'b1, 16'h0000, 8'hA5, 1'b1);
    tbl[25] = mk(2'b01, 9'h1FF, 16'h0000, 8'h00, 1'b1, 16'h0000, 8'hA5, 1'b1);
    tbl[26] = mk(2'b00, 9'h000, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'hA5, 1'b1);
    tbl[27] = mk(2'b01, 9'h005, 16'h0000, 8'h00, 1'b1, 16'hABCD, 8'hA5, 1'b1);
    tbl[28] = mk(2'b00, 9'h000, 16'h0000, 8'h00, 1'b0, 16'hABCD, 8'hA5, 1'b1);

    // ---- reset state ----
    reset = 1'b0;
    drive(2'b00, 9'h000, 16'h0000, 8'h00);
    model_reset();
    #2;
    chk4("reset", 1'b0, 16'h0000, 8'h00, 1'b0);
    step();
    step();
    reset = 1'b1;

    // ---- preload RAM with a known pattern (consecutive distinct writes) ----
    for (int i = 0; i < 256; i++) begin
      drive(2'b10, 9'(i), {8'hC0, 8'(i)}, 8'h00);
      step();
    end
    drive(2'b00, 9'h000, 16'h0000, 8'h00);
    step();

    // ---- directed table ----
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].cmd, tbl[i].addr, tbl[i].wd, tbl[i].sw);
      step();
      chk4($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_rd, tbl[i].e_led, tbl[i].e_err);
    end

    // ---- reset pulse clears sticky error ----
    reset = 1'b0;
    model_reset();
    #1;
    chk4("errclr", 1'b0, 16'h0000, 8'h00, 1'b0);
    step();
    reset = 1'b1;

    // ---- reset asserted before the edge of a WRITE: no write ----
    drive(2'b10, 9'h020, 16'h0000, 8'h00); step();
    drive(2'b10, 9'h100, 16'h005A, 8'h00); step();
    drive(2'b01, 9'h005, 16'h0000, 8'h00); step();
    chk4("rstA_pre", 1'b1, 16'hABCD, 8'h5A, 1'b0);
    drive(2'b10, 9'h020, 16'hCAFE, 8'h00);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk4("rstA_async", 1'b0, 16'h0000, 8'h00, 1'b0);
    step();
    drive(2'b00, 9'h000, 16'h0000, 8'h00);
    reset = 1'b1;
    step();
    drive(2'b01, 9'h020, 16'h0000, 8'h00); step();
    chk4("rstA_read", 1'b1, 16'h0000, 8'h00, 1'b0);

    // ---- reset during ACK of a WRITE: write already committed ----
    drive(2'b10, 9'h100, 16'h00C3, 8'h00); step();
    drive(2'b01, 9'h005, 16'h0000, 8'h00); step();
    drive(2'b10, 9'h020, 16'hBEEF, 8'h00); step();
    chk4("rstB_ack", 1'b1, 16'hABCD, 8'hC3, 1'b0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk4("rstB_async", 1'b0, 16'h0000, 8'h00, 1'b0);
    drive(2'b01, 9'h020, 16'h0000, 8'h00);
    step();
    reset = 1'b1;
    step();
    chk4("rstB_new", 1'b1, 16'hBEEF, 8'h00, 1'b0);
    step();
    chk4("rstB_hold", 1'b0, 16'hBEEF, 8'h00, 1'b0);

    // ---- randomized traffic against the model ----
    for (int k = 0; k < 3000; k++) begin
      int r;
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        model_reset();
        #1;
        chk4("rnd_rst", 1'b0, 16'h0000, 8'h00, 1'b0);
        step();
        reset = 1'b1;
      end
      if ($urandom_range(0, 2) != 0) begin
        r = $urandom_range(0, 99);
        mem_cmd = (r < 25) ? 2'b00 : (r < 60) ? 2'b01 : (r < 90) ? 2'b10 : 2'b11;
        r = $urandom_range(0, 9);
        case (r)
          6:       mem_addr = 9'h100;
          7:       mem_addr = 9'h140;
          8, 9:    mem_addr = 9'h100 | 9'($urandom_range(0, 255));
          default: mem_addr = 9'($urandom_range(0, 15));
        endcase
      end
      write_data = 16'($urandom);
      sw         = 8'($urandom);
      step();
      chk4($sformatf("rnd%0d", k), m_rdy, m_rd, m_led, m_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; the ports are named clk and reset as elsewhere in the codebase.
REQ-002 SHALL define parameters:
- RAM_WORDS, default 256, number of 16-bit RAM words.
- LED_ADDR, default 9'h100, LED output register address.
- SW_ADDR, default 9'h140, switch input address.
REQ-003 SHALL have these ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- mem_cmd  in  2  command: 00 NONE, 01 READ, 10 WRITE, 11 illegal.
- mem_addr  in  9  word address.
- write_data  in  16  store data.
- sw  in  8  switch inputs.
- read_data  out  16  registered read data.
- rdy  out  1  one-cycle acknowledge of a new access.
- ledr  out  8  LED register.
- err  out  1  sticky error flag.

Function
REQ-004 SHALL decode addresses as follows:
- mem_addr[8]=0: RAM, word index mem_addr[7:0].
- mem_addr==SW_ADDR: switch port, read-only.
- mem_addr==LED_ADDR: LED port, write-only.
- Any other address with mem_addr[8]=1: unmapped.
REQ-005 SHALL implement FSM states IDLE, ACK and HOLD, encoded in 2 bits; any unused encoding SHALL go to IDLE on the next clock.
REQ-006 SHALL latch {mem_cmd, mem_addr} as the current access on every edge that enters ACK.
REQ-007 SHALL take these transitions from IDLE:
- mem_cmd NONE: stay in IDLE.
- mem_cmd READ, WRITE or 11: go to ACK.
REQ-008 SHALL go from ACK to HOLD when {mem_cmd, mem_addr} equals the latched value, to IDLE when mem_cmd is NONE, and to ACK again (new access) otherwise.
REQ-009 SHALL remain in HOLD while {mem_cmd, mem_addr} equals the latched value, go to IDLE when mem_cmd is NONE, and go to ACK when the command or address changes.
REQ-010 SHALL assert rdy (registered) for exactly the one cycle spent in ACK; back-to-back distinct accesses SHALL therefore give consecutive rdy pulses.
REQ-011 SHALL, on every edge where mem_cmd is READ, load read_data as follows, whatever the FSM state:
- RAM address: the RAM word.
- SW_ADDR: {8'h00, sw}.
- LED_ADDR or unmapped: 16'h0000.
This gives one-cycle read latency, and data tracks a held READ.
REQ-012 SHALL hold read_data unchanged on edges where mem_cmd is not READ.
REQ-013 SHALL commit a WRITE exactly once per access, on the edge that enters ACK; a WRITE held in HOLD SHALL NOT rewrite.
REQ-014 SHALL handle WRITE targets as follows:
- RAM address: writes write_data to the RAM word.
- LED_ADDR: loads ledr with write_data[7:0].
- SW_ADDR: ignored and sets err.
REQ-015 SHALL set err on the ACK-entry edge for: mem_cmd=11, a READ of an unmapped address, or a WRITE of an unmapped address or SW_ADDR.
REQ-016 SHALL make an erroneous access complete normally (rdy pulses) with no RAM or ledr change.
REQ-017 SHALL keep err set until reset; err is not cleared by any command.
REQ-018 SHALL return the pre-write RAM value when a READ to an address immediately follows a WRITE to the same address in the next cycle? No: it SHALL return the newly written value (write-then-read ordering across consecutive cycles).
REQ-019 SHALL have no combinational path from any input to any output.

Reset
REQ-020 SHALL, while reset=0, asynchronously force: state=IDLE, rdy=0, read_data=16'h0000, ledr=8'h00, err=0, latched access cleared.
REQ-021 SHALL NOT clear RAM contents on reset.
REQ-022 SHALL, when reset is asserted mid-access, abandon the access with no partial write; after reset deasserts, a still-present command SHALL be treated as a new access from IDLE.

Verification
REQ-023 Write then read:
- Stimulus: WRITE addr 9'h005 data 16'hABCD for 1 cycle; NONE; READ addr 9'h005 held 2 cycles.
- Required: rdy pulses on each access; read_data=16'hABCD after the first READ edge and stays so.
REQ-024 Held write:
- Stimulus: WRITE addr 9'h010 data 16'h1111 held 3 cycles, with write_data changed to 16'h2222 in cycles 2-3; then read addr 9'h010.
- Required: reads 16'h1111; rdy high for one cycle only.
REQ-025 LED and switch ports:
- Stimulus: WRITE LED_ADDR data 16'h00A5; sw=8'h3C; READ SW_ADDR.
- Required: ledr=8'hA5; read_data=16'h003C; err=0.
REQ-026 Error cases:
- Stimulus: mem_cmd=11; then WRITE SW_ADDR; then READ 9'h1FF.
- Required: err rises on the first access and stays 1; read_data=16'h0000; RAM and ledr unchanged.
- Stimulus: reset pulse.
- Required: err=0.
REQ-027 Address change while holding:
- Stimulus: READ 9'h001 held 2 cycles, then READ 9'h002 without an intervening NONE.
- Required: a second rdy pulse; read_data follows each address with one-cycle latency.
REQ-028 Reset mid-access:
- Stimulus: reset=0 asynchronously during ACK of a WRITE to 9'h020 whose value was 16'h0000 before the test.
- Required: outputs clear immediately.
- Stimulus: release reset with NONE, then READ 9'h020.
- Required: read_data=16'h0000, or the committed value only if the write edge preceded reset.
